mem_queue: RTL and testbench
============================

# mem_queue

Memory-operation queue directly downstream of the integer execute stage. It accepts resolved load/store requests (`mem_vld`/`mem_para`/`mem_addr`/`mem_wdata`) and buffers them in order in a small FIFO. It issues them one at a time on a word-wide data bus with a req/gnt handshake. Load results are sign- or zero-extended and returned to the multi-port register file.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.
- `DEPTH`, 4: FIFO entries; a power of two, ≥2.
- `MEMB_PARA`, 9: width of `mem_para`, packed `{rd[4:0], funct3[2:0], is_store}`.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock domain.
- `mem_vld`  in  1  execute stage presents a memory op this cycle.
- `mem_para`  in  MEMB_PARA  {rd, funct3, is_store}.
- `mem_addr`  in  XLEN  effective byte address.
- `mem_wdata`  in  XLEN  store data (rs2).
- `mem_rdy`  out  1  FIFO not full; push occurs on `mem_vld & mem_rdy`.
- `mem_empty`  out  1  FIFO empty and FSM IDLE (used for fence drain).
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  XLEN  word address, bits [1:0] = 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  XLEN  lane-replicated store data.
- `dmem_gnt`  in  1  bus accepts the request this cycle.
- `dmem_rvld`  in  1  read data valid.
- `dmem_rdata`  in  XLEN  read word.
- `ld_vld`  out  1  one-cycle load writeback pulse.
- `ld_sel`  out  5  destination register.
- `ld_data`  out  XLEN  extended load value.
- `mem_err`  out  1  one-cycle pulse: misaligned or illegal-funct3 op dropped.

## Operation
- FIFO:
  - Entries hold {para, addr, wdata}; in-order, with `log2(DEPTH)+1`-bit wrapping read/write pointers.
  - Full means the pointer MSBs differ and the low bits are equal.
  - A push while full is refused, even in a cycle that also pops.
- FSM states are IDLE, REQ and WAIT.
  - IDLE with FIFO non-empty, head legal → REQ.
  - IDLE with FIFO non-empty, head illegal → pop, pulse `mem_err`, stay IDLE.
  - REQ holds `dmem_req`=1 and bus outputs stable until `dmem_gnt`.
    - Store granted → pop, IDLE.
    - Load granted → WAIT.
  - WAIT: on `dmem_rvld` → pop, register `ld_*`, IDLE.
  - `dmem_rvld` is ignored outside WAIT.
- Legality:
  - Loads: funct3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: funct3 ∈ {000 SB, 001 SH, 010 SW}.
  - Halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
- Stores:
  - `be`: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111.
  - `wdata`: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- Loads:
  - Select the byte/half lane by addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - `be` for loads follows the same rule as stores.
  - rd=0: the bus access still occurs, but `ld_vld` stays 0.
- Only one bus transaction is outstanding at a time.

## Timing
- Reset values:
  - Pointers, FSM state, `dmem_req`, `dmem_we`, `ld_vld` and `mem_err` are 0/IDLE.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `ld_sel` and `ld_data` are 0.
  - `mem_rdy`=1, `mem_empty`=1.
- Bus outputs are registered. For a push at edge E0 into an empty queue, `dmem_req` is high after E1.
- Store latency is 2 cycles plus grant wait. A grant in the first REQ cycle retires the store at that edge.
- Load: `ld_vld` pulses in the cycle after the `dmem_rvld` edge; `ld_sel`/`ld_data` stay valid and are held until the next load.
- Back-to-back ops each pass through IDLE, so there is at least one idle bus cycle between transactions.
- An asynchronous reset in REQ/WAIT discards the FIFO and any in-flight op; a late `dmem_rvld` is ignored.
- `mem_err` is registered and pulses for one cycle per dropped entry.

## Structure
- Shared package/define file holds:
  - `XLEN`, `MEMB_PARA`, `N(x)`.
  - The funct3 encodings (LB..LHU, SB..SW).
  - The FSM state encodings.
- One sub-module, `mem_fifo` (generic DEPTH×width synchronous FIFO with full/empty). Lane select/extension stays inline.

## Test plan
- SW at 0x100, data 0xDEADBEEF, gnt after 2 cycles → `dmem_we`=1, `addr`=0x100, `be`=1111, `wdata`=0xDEADBEEF held 2 cycles; then `mem_empty`=1.
- SB 0x5A at 0x203 → `addr`=0x200, `be`=1000, `wdata`=0x5A5A5A5A.
- LB rd=5 at 0x102, `rdata`=0x0080FF00 → `ld_sel`=5, `ld_data`=0xFFFFFF80; LBU gives 0x00000080; LH at 0x102 gives 0x00000080.
- LW at 0x101 → no `dmem_req`, `mem_err` pulses once, entry popped; a following LW rd=0 at 0x104 → bus read occurs, `ld_vld` stays 0.
- Push 4 ops with gnt held low → `mem_rdy`=0 after the fourth push; a fifth `mem_vld` is refused; release gnt → ops issue in push order.
- Reset asserted in WAIT, then `dmem_rvld` after release → no `ld_vld`; all outputs at reset values.

Source files
------------

// File: rtl/mem_queue_pkg.sv
// Shared types, widths and decode helpers for the memory-operation queue.
package mem_queue_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MEMB_PARA = 9;

    // Pointer index width for an x-entry buffer (at least one bit).
    function automatic int unsigned N(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       is_store;
    } mem_para_t;

    typedef struct packed {
        mem_para_t       para;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_entry_t;

    // Known funct3 for the op kind and natural alignment of the access size.
    function automatic logic op_legal(input mem_para_t p, input logic [1:0] a);
        logic f3_ok;
        logic align_ok;
        if (p.is_store) begin
            f3_ok = (p.funct3 == F3_SB) || (p.funct3 == F3_SH) || (p.funct3 == F3_SW);
        end else begin
            f3_ok = (p.funct3 == F3_LB) || (p.funct3 == F3_LH) || (p.funct3 == F3_LW) ||
                    (p.funct3 == F3_LBU) || (p.funct3 == F3_LHU);
        end
        case (p.funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~a[0];
            default: align_ok = (a == 2'b00);
        endcase
        return f3_ok & align_ok;
    endfunction

    // Byte enables from access size and byte offset.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'(4'b0001 << a);
            2'b01:   return 4'(4'b0011 << a);
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_fifo.sv
// Generic in-order FIFO with wrapping pointers; refuses pushes while full.
module mem_fifo
    import mem_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = N(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage; contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mem_queue.sv
// Memory-op queue: buffers load/store requests and issues them one at a time on the data bus.
module mem_queue
    import mem_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_vld,
    input  logic [MEMB_PARA-1:0] mem_para,
    input  logic [XLEN-1:0]      mem_addr,
    input  logic [XLEN-1:0]      mem_wdata,
    output logic                 mem_rdy,
    output logic                 mem_empty,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvld,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 ld_vld,
    output logic [4:0]           ld_sel,
    output logic [XLEN-1:0]      ld_data,
    output logic                 mem_err
);

    mem_entry_t      push_entry;
    mem_entry_t      head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            head_ok;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] st_data;

    state_t          state_q, state_d;
    logic            req_d, we_d, ld_vld_d, err_d;
    logic [XLEN-1:0] addr_d, wdata_d, ld_data_d;
    logic [3:0]      be_d;
    logic [4:0]      ld_sel_d;

    assign push_entry = {mem_para, mem_addr, mem_wdata};

    mem_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(mem_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (mem_vld),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mem_rdy   = ~fifo_full;
    assign mem_empty = fifo_empty && (state_q == ST_IDLE);
    assign head_ok   = op_legal(head.para, head.addr[1:0]);

    // Lane replication for stores and lane select/extension for loads.
    always_comb begin
        lane    = dmem_rdata >> {head.addr[1:0], 3'b000};
        ld_ext  = dmem_rdata;
        st_data = head.wdata;
        case (head.para.funct3)
            F3_LB:   ld_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_LH:   ld_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_LBU:  ld_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_LHU:  ld_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: ld_ext = dmem_rdata;
        endcase
        case (head.para.funct3[1:0])
            2'b00:   st_data = {4{head.wdata[7:0]}};
            2'b01:   st_data = {2{head.wdata[15:0]}};
            default: st_data = head.wdata;
        endcase
    end

    // Next-state and next-output decode for the issue FSM.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        req_d     = dmem_req;
        we_d      = dmem_we;
        addr_d    = dmem_addr;
        be_d      = dmem_be;
        wdata_d   = dmem_wdata;
        ld_vld_d  = 1'b0;
        ld_sel_d  = ld_sel;
        ld_data_d = ld_data;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_ok) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        we_d    = head.para.is_store;
                        addr_d  = {head.addr[XLEN-1:2], 2'b00};
                        be_d    = byte_en(head.para.funct3, head.addr[1:0]);
                        wdata_d = st_data;
                    end else begin
                        fifo_pop = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (head.para.is_store) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvld) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                    if (head.para.rd != 5'd0) begin
                        ld_vld_d  = 1'b1;
                        ld_sel_d  = head.para.rd;
                        ld_data_d = ld_ext;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered bus/writeback outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            ld_vld     <= 1'b0;
            ld_sel     <= '0;
            ld_data    <= '0;
            mem_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
            ld_vld     <= ld_vld_d;
            ld_sel     <= ld_sel_d;
            ld_data    <= ld_data_d;
            mem_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_queue.sv
// Self-checking bench for mem_queue: directed scenarios plus randomized single-op traffic.
module tb_mem_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_vld;
    logic [8:0]  mem_para;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdy;
    logic        mem_empty;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvld;
    logic [31:0] dmem_rdata;
    logic        ld_vld;
    logic [4:0]  ld_sel;
    logic [31:0] ld_data;
    logic        mem_err;

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;

    mem_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_vld    (mem_vld),
        .mem_para   (mem_para),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdy    (mem_rdy),
        .mem_empty  (mem_empty),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvld  (dmem_rvld),
        .dmem_rdata (dmem_rdata),
        .ld_vld     (ld_vld),
        .ld_sel     (ld_sel),
        .ld_data    (ld_data),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        if (st && f3 > 3'd2) return 0;
        if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        return (a % acc_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned s = acc_size(f3);
        int unsigned v = ((1 << s) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (acc_size(f3))
            1:       return 32'(d % 256) * 32'h01010101;
            2:       return 32'(d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        int unsigned s = acc_size(f3);
        longint v;
        longint span;
        if (s >= 4) return r;
        span = longint'(1) << (8 * s);
        v = (longint'(r) >> (8 * (a % 4))) % span;
        if (f3 < 3'd4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input logic [8:0] p, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!mem_rdy && n < 50) begin
            step();
            n++;
        end
        chk("push_rdy", 32'(mem_rdy), 32'd1);
        mem_vld   = 1'b1;
        mem_para  = p;
        mem_addr  = a;
        mem_wdata = d;
        step();
        mem_vld   = 1'b0;
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (!dmem_req && n < limit) begin
            step();
            n++;
        end
    endtask

    // Push one op into an idle queue and drive it to completion.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] d, input int gd, input int rdl,
                          input logic [31:0] rdat);
        logic [31:0] exp_ld;
        push_op({rd, f3, st}, a, d);
        step();
        if (!m_legal(st, f3, a)) begin
            chk({tag, "_err"}, 32'(mem_err), 32'd1);
            chk({tag, "_noreq"}, 32'(dmem_req), 32'd0);
            step();
            chk({tag, "_err_clr"}, 32'(mem_err), 32'd0);
            chk({tag, "_empty"}, 32'(mem_empty), 32'd1);
        end else begin
            chk({tag, "_req"}, 32'(dmem_req), 32'd1);
            chk({tag, "_we"}, 32'(dmem_we), 32'(st));
            chk({tag, "_addr"}, dmem_addr, a & 32'hFFFF_FFFC);
            chk({tag, "_be"}, 32'(dmem_be), 32'(m_be(f3, a)));
            if (st) chk({tag, "_wdata"}, dmem_wdata, m_wdata(f3, d));
            for (int i = 0; i < gd; i++) begin
                step();
                chk({tag, "_req_hold"}, 32'(dmem_req), 32'd1);
                chk({tag, "_addr_hold"}, dmem_addr, a & 32'hFFFF_FFFC);
                if (st) chk({tag, "_wdata_hold"}, dmem_wdata, m_wdata(f3, d));
            end
            dmem_gnt = 1'b1;
            step();
            dmem_gnt = 1'b0;
            chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
            if (st) begin
                chk({tag, "_st_empty"}, 32'(mem_empty), 32'd1);
            end else begin
                chk({tag, "_busy"}, 32'(mem_empty), 32'd0);
                for (int i = 0; i < rdl; i++) step();
                dmem_rvld  = 1'b1;
                dmem_rdata = rdat;
                step();
                dmem_rvld  = 1'b0;
                chk({tag, "_ld_vld"}, 32'(ld_vld), (rd != 5'd0) ? 32'd1 : 32'd0);
                if (rd != 5'd0) begin
                    exp_ld = m_load(f3, a, rdat);
                    chk({tag, "_ld_sel"}, 32'(ld_sel), 32'(rd));
                    chk({tag, "_ld_data"}, ld_data, exp_ld);
                end
                chk({tag, "_ld_empty"}, 32'(mem_empty), 32'd1);
                step();
                chk({tag, "_ld_pulse"}, 32'(ld_vld), 32'd0);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(mem_rdy), 32'd1);
        chk({tag, "_empty"}, 32'(mem_empty), 32'd1);
        chk({tag, "_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_we"}, 32'(dmem_we), 32'd0);
        chk({tag, "_addr"}, dmem_addr, 32'd0);
        chk({tag, "_be"}, 32'(dmem_be), 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_ld_vld"}, 32'(ld_vld), 32'd0);
        chk({tag, "_ld_sel"}, 32'(ld_sel), 32'd0);
        chk({tag, "_ld_data"}, ld_data, 32'd0);
        chk({tag, "_err"}, 32'(mem_err), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic        st;
        logic [2:0]  f3;

        rst        = 1'b0;
        mem_vld    = 1'b0;
        mem_para   = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        dmem_gnt   = 1'b0;
        dmem_rvld  = 1'b0;
        dmem_rdata = '0;

        step();
        step();
        chk_reset_vals("rst_held");
        rst = 1'b1;
        step();
        chk_reset_vals("rst_rel");

        // SW 0xDEADBEEF at 0x100, grant after two cycles
        run_op("sw", 1'b1, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0);
        // SB 0x5A at 0x203
        run_op("sb", 1'b1, 3'b000, 5'd0, 32'h203, 32'h0000005A, 0, 0, 32'h0);
        chk("sb_be_const", 32'(dmem_be), 32'h8);
        chk("sb_wdata_const", dmem_wdata, 32'h5A5A5A5A);
        // LB / LBU / LH at 0x102
        run_op("lb", 1'b0, 3'b000, 5'd5, 32'h102, 32'h0, 1, 1, 32'h0080FF00);
        chk("lb_const", ld_data, 32'hFFFFFF80);
        chk("lb_sel_const", 32'(ld_sel), 32'd5);
        run_op("lbu", 1'b0, 3'b100, 5'd6, 32'h102, 32'h0, 0, 2, 32'h0080FF00);
        chk("lbu_const", ld_data, 32'h00000080);
        run_op("lh", 1'b0, 3'b001, 5'd7, 32'h102, 32'h0, 0, 0, 32'h0080FF00);
        chk("lh_const", ld_data, 32'h00000080);
        // Misaligned LW dropped, then LW rd=0 still reaches the bus
        run_op("lw_mis", 1'b0, 3'b010, 5'd8, 32'h101, 32'h0, 0, 0, 32'h0);
        run_op("lw_rd0", 1'b0, 3'b010, 5'd0, 32'h104, 32'h0, 0, 0, 32'h12345678);
        chk("lw_rd0_held", ld_data, 32'h00000080);
        // Illegal funct3 store
        run_op("sx_bad", 1'b1, 3'b011, 5'd0, 32'h100, 32'h0, 0, 0, 32'h0);

        // Fill the queue with grant held low
        for (int i = 0; i < 4; i++) push_op({5'd0, 3'b010, 1'b1}, 32'h400 + 32'(4 * i), 32'hA000 + 32'(i));
        chk("full_rdy", 32'(mem_rdy), 32'd0);
        mem_vld   = 1'b1;
        mem_para  = {5'd0, 3'b010, 1'b1};
        mem_addr  = 32'h500;
        mem_wdata = 32'hBAD;
        step();
        mem_vld   = 1'b0;
        chk("full_refuse_rdy", 32'(mem_rdy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_req(4);
            chk("drain_req", 32'(dmem_req), 32'd1);
            chk("drain_addr", dmem_addr, 32'h400 + 32'(4 * i));
            chk("drain_wdata", dmem_wdata, 32'hA000 + 32'(i));
            dmem_gnt = 1'b1;
            step();
            dmem_gnt = 1'b0;
            chk("drain_gap", 32'(dmem_req), 32'd0);
        end
        step();
        step();
        chk("drain_no5th", 32'(dmem_req), 32'd0);
        chk("drain_empty", 32'(mem_empty), 32'd1);

        // Randomized single ops
        for (int k = 0; k < 40; k++) begin
            st = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            a  = 32'h1000 + 32'($urandom % 64);
            if ($urandom % 4 != 0) begin
                if (st) f3 = 3'($urandom % 3);
                else    f3 = (($urandom % 2) != 0) ? 3'($urandom % 3) : 3'(4 + $urandom % 2);
                a = a & ~32'(acc_size(f3) - 1);
            end
            run_op("rnd", st, f3, 5'($urandom % 32), a, $urandom, int'($urandom % 3),
                   int'($urandom % 3), $urandom);
        end

        // Reset in WAIT discards the in-flight load; late read data is ignored
        push_op({5'd3, 3'b010, 1'b0}, 32'h100, 32'h0);
        step();
        chk("wr_req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        rst = 1'b0;
        #2;
        chk_reset_vals("wr_async");
        step();
        rst = 1'b1;
        dmem_rvld  = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_rvld  = 1'b0;
        chk_reset_vals("wr_late");
        step();
        chk_reset_vals("wr_after");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
